// File: rtl/ram_test_pkg.sv
// Shared types and the expected-data rule for the RAM write/verify engine.
package ram_test_pkg;

  // Widest geometry the pattern function handles; instances narrow the result.
  localparam int MAX_ADDR_W = 8;
  localparam int MAX_DATA_W = 2 * MAX_ADDR_W;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_READ,
    S_DRAIN,
    S_DONE
  } state_e;

  typedef enum logic [1:0] {
    MODE_USER = 2'b00,
    MODE_ZERO = 2'b01,
    MODE_ONES = 2'b10,
    MODE_ADDR = 2'b11
  } mode_e;

  // Word expected at addr for the given pattern; aw is the real address width,
  // so MODE_ADDR yields {~addr, addr} packed into the low 2*aw bits.
  function automatic logic [MAX_DATA_W-1:0] expected(
    input mode_e                  mode,
    input logic [MAX_DATA_W-1:0]  user,
    input logic [MAX_ADDR_W-1:0]  addr,
    input int unsigned            aw
  );
    logic [MAX_DATA_W-1:0] mask;
    logic [MAX_DATA_W-1:0] a_ext;
    mask     = (MAX_DATA_W'(1) << aw) - MAX_DATA_W'(1);
    a_ext    = MAX_DATA_W'(addr) & mask;
    expected = '0;
    case (mode)
      MODE_USER: expected = user;
      MODE_ZERO: expected = '0;
      MODE_ONES: expected = '1;
      MODE_ADDR: expected = ((~a_ext & mask) << aw) | a_ext;
    endcase
  endfunction

endpackage

// File: rtl/ram_bist_sequencer_if.sv
// RAM-side bus between the sequencer (master) and the lab RAM (slave).
interface ram_bist_sequencer_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
);
  logic [ADDR_W-1:0] ram_address;
  logic [DATA_W-1:0] ram_data;
  logic              ram_wren;
  logic [DATA_W-1:0] ram_q;

  modport master (output ram_address, ram_data, ram_wren, input ram_q);
  modport slave  (input ram_address, ram_data, ram_wren, output ram_q);
endinterface

// File: rtl/ram_pattern_gen.sv
// Combinational expected-data generator for one address.
module ram_pattern_gen
  import ram_test_pkg::*;
#(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input  mode_e             mode,
  input  logic [DATA_W-1:0] user,
  input  logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] data
);
  // Widen into the package function's fixed-width domain, then trim back.
  assign data = DATA_W'(expected(mode, MAX_DATA_W'(user), MAX_ADDR_W'(addr), ADDR_W));
endmodule

// File: rtl/ram_bist_sequencer.sv
// Write-then-verify sequencer for the lab RAM: fills every address with a
// pattern, reads it all back, counts mismatches and records the first one.
module ram_bist_sequencer
  import ram_test_pkg::*;
#(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8,
  parameter int RD_LAT = 1
) (
  input  logic                  clock,
  input  logic                  clear,
  input  logic                  start,
  input  logic [1:0]            mode,
  input  logic [DATA_W-1:0]     DataIn,
  ram_bist_sequencer_if.master  ram,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [ADDR_W:0]       err_count,
  output logic [ADDR_W-1:0]     fail_address,
  output logic [DATA_W-1:0]     fail_data
);
  localparam logic [ADDR_W-1:0] ADDR_MAX   = '1;
  localparam logic [1:0]        DRAIN_LAST = 2'(RD_LAT - 1);

  state_e                    state_q, state_d;
  mode_e                     mode_q, mode_d;
  logic [DATA_W-1:0]         user_q, user_d;
  logic [ADDR_W-1:0]         addr_q, addr_d;
  logic [DATA_W-1:0]         wdata_q, wdata_d;
  logic                      wren_q, wren_d;
  logic [1:0]                drain_q, drain_d;
  logic [RD_LAT:1]           vld_pipe_q, vld_pipe_d;
  logic [RD_LAT:1][ADDR_W-1:0] apipe_q, apipe_d;
  logic [ADDR_W:0]           err_q, err_d;
  logic [ADDR_W-1:0]         faddr_q, faddr_d;
  logic [DATA_W-1:0]         fdata_q, fdata_d;
  logic                      pass_q, pass_d;

  // A run may launch from IDLE or straight out of DONE so a held start
  // re-runs back to back with no idle gap.
  logic              launch;
  mode_e             wr_mode;
  logic [DATA_W-1:0] wr_user;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_exp;
  logic [DATA_W-1:0] cmp_exp;

  assign launch  = start && (state_q == S_IDLE || state_q == S_DONE);
  // Write-path generator looks at the word that will be driven next cycle.
  assign wr_mode = launch ? mode_e'(mode) : mode_q;
  assign wr_user = launch ? DataIn : user_q;
  assign wr_addr = launch ? '0 : addr_q + 1'b1;

  ram_pattern_gen #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_wr_gen (
    .mode(wr_mode), .user(wr_user), .addr(wr_addr), .data(wr_exp)
  );

  ram_pattern_gen #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_cmp_gen (
    .mode(mode_q), .user(user_q), .addr(apipe_q[RD_LAT]), .data(cmp_exp)
  );

  // Next-state, address counter, read delay line and result accumulation.
  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    user_d   = user_q;
    addr_d   = addr_q;
    wdata_d  = '0;
    wren_d   = 1'b0;
    drain_d  = drain_q;
    err_d    = err_q;
    faddr_d  = faddr_q;
    fdata_d  = fdata_q;
    pass_d   = pass_q;

    vld_pipe_d[1] = (state_q == S_READ);
    apipe_d[1]    = addr_q;
    for (int i = 2; i <= RD_LAT; i++) begin
      vld_pipe_d[i] = vld_pipe_q[i-1];
      apipe_d[i]    = apipe_q[i-1];
    end

    // Tail of the delay line lines up with ram_q for that address.
    if (vld_pipe_q[RD_LAT] && (ram.ram_q != cmp_exp)) begin
      if (err_q == '0) begin
        faddr_d = apipe_q[RD_LAT];
        fdata_d = ram.ram_q;
      end
      err_d = err_q + 1'b1;
    end

    case (state_q)
      S_IDLE, S_DONE: state_d = S_IDLE;
      S_WRITE: begin
        if (addr_q == ADDR_MAX) begin
          state_d = S_READ;
          addr_d  = '0;
        end else begin
          addr_d  = addr_q + 1'b1;
          wren_d  = 1'b1;
          wdata_d = wr_exp;
        end
      end
      S_READ: begin
        if (addr_q == ADDR_MAX) begin
          state_d = S_DRAIN;
          drain_d = '0;
        end else begin
          addr_d = addr_q + 1'b1;
        end
      end
      S_DRAIN: begin
        if (drain_q == DRAIN_LAST) begin
          state_d = S_DONE;
          pass_d  = (err_d == '0);
        end else begin
          drain_d = drain_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (launch) begin
      state_d = S_WRITE;
      mode_d  = wr_mode;
      user_d  = DataIn;
      addr_d  = '0;
      wren_d  = 1'b1;
      wdata_d = wr_exp;
      err_d   = '0;
      faddr_d = '0;
      fdata_d = '0;
      pass_d  = 1'b0;
    end
  end

  // State and output registers; clear returns everything to idle zeros.
  always_ff @(posedge clock) begin
    if (clear) begin
      state_q    <= S_IDLE;
      mode_q     <= MODE_USER;
      user_q     <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      wren_q     <= 1'b0;
      drain_q    <= '0;
      vld_pipe_q <= '0;
      apipe_q    <= '0;
      err_q      <= '0;
      faddr_q    <= '0;
      fdata_q    <= '0;
      pass_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      user_q     <= user_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      wren_q     <= wren_d;
      drain_q    <= drain_d;
      vld_pipe_q <= vld_pipe_d;
      apipe_q    <= apipe_d;
      err_q      <= err_d;
      faddr_q    <= faddr_d;
      fdata_q    <= fdata_d;
      pass_q     <= pass_d;
    end
  end

  assign ram.ram_address = addr_q;
  assign ram.ram_data    = wdata_q;
  assign ram.ram_wren    = wren_q;
  assign busy            = (state_q == S_WRITE) || (state_q == S_READ) || (state_q == S_DRAIN);
  assign done            = (state_q == S_DONE);
  assign pass            = pass_q;
  assign err_count       = err_q;
  assign fail_address    = faddr_q;
  assign fail_data       = fdata_q;

endmodule

// File: tb/tb_ram_bist_sequencer.sv
// Bench: two sequencers (read latency 1 and 2) each on a behavioural RAM with
// injectable faults, checked every cycle against a timeline model.
module tb_ram_bist_sequencer;
  logic       clock = 1'b0;
  logic       clear = 1'b1;
  logic [1:0] start_i = '0;
  logic [1:0] mode = '0;
  logic [7:0] DataIn = '0;
  logic       stuck0 = 1'b0;
  logic       corrupt15 = 1'b0;
  logic       chk_en = 1'b0;
  int         checks = 0;
  int         errors = 0;

  always #5 clock = ~clock;

  ram_bist_sequencer_if #(.ADDR_W(4), .DATA_W(8)) bus0 ();
  ram_bist_sequencer_if #(.ADDR_W(4), .DATA_W(8)) bus1 ();

  logic [1:0]      busy_o, done_o, pass_o, wren_o;
  logic [1:0][4:0] err_o;
  logic [1:0][3:0] fa_o, addr_o;
  logic [1:0][7:0] fd_o, data_o;

  assign addr_o[0] = bus0.ram_address;
  assign data_o[0] = bus0.ram_data;
  assign wren_o[0] = bus0.ram_wren;
  assign addr_o[1] = bus1.ram_address;
  assign data_o[1] = bus1.ram_data;
  assign wren_o[1] = bus1.ram_wren;

  ram_bist_sequencer #(.ADDR_W(4), .DATA_W(8), .RD_LAT(1)) dut0 (
    .clock(clock), .clear(clear), .start(start_i[0]), .mode(mode), .DataIn(DataIn),
    .ram(bus0.master), .busy(busy_o[0]), .done(done_o[0]), .pass(pass_o[0]),
    .err_count(err_o[0]), .fail_address(fa_o[0]), .fail_data(fd_o[0])
  );

  ram_bist_sequencer #(.ADDR_W(4), .DATA_W(8), .RD_LAT(2)) dut1 (
    .clock(clock), .clear(clear), .start(start_i[1]), .mode(mode), .DataIn(DataIn),
    .ram(bus1.master), .busy(busy_o[1]), .done(done_o[1]), .pass(pass_o[1]),
    .err_count(err_o[1]), .fail_address(fa_o[1]), .fail_data(fd_o[1])
  );

  // Stored word after fault injection: bit 0 stuck low and/or address 15 flipped.
  function automatic logic [7:0] fault(input logic [7:0] v, input logic st, input logic c15, input int a);
    return (st ? (v & 8'hFE) : v) ^ ((c15 && a == 15) ? 8'h01 : 8'h00);
  endfunction

  function automatic logic [7:0] pat(input logic [1:0] md, input logic [7:0] u, input int a);
    case (md)
      2'd0:    return u;
      2'd1:    return 8'h00;
      2'd2:    return 8'hFF;
      default: return 8'((15 - a) * 16 + a);
    endcase
  endfunction

  // RAMs: 1-cycle and 2-cycle read latency.
  logic [7:0] mem0 [16];
  logic [7:0] mem1 [16];
  logic [7:0] q1a;

  always @(posedge clock) begin
    if (bus0.ram_wren) mem0[bus0.ram_address] <= fault(bus0.ram_data, stuck0, corrupt15, int'(bus0.ram_address));
    bus0.ram_q <= mem0[bus0.ram_address];
  end

  always @(posedge clock) begin
    if (bus1.ram_wren) mem1[bus1.ram_address] <= fault(bus1.ram_data, stuck0, corrupt15, int'(bus1.ram_address));
    q1a        <= mem1[bus1.ram_address];
    bus1.ram_q <= q1a;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", nm, act, exp);
    end
  endtask

  // Timeline model: t = cycle number within a run (1 = first write cycle),
  // -1 = cleared, 1000 = finished and holding results.
  int         t [2] = '{-1, -1};
  logic [1:0] m_mode [2];
  logic [7:0] m_user [2];
  logic       m_st [2];
  logic       m_c15 [2];

  function automatic int done_t(input int d);
    return 34 + d;
  endfunction

  always @(posedge clock) begin
    for (int d = 0; d < 2; d++) begin
      if (clear) t[d] <= -1;
      else if (start_i[d] && (t[d] < 0 || t[d] >= done_t(d))) begin
        t[d]      <= 1;
        m_mode[d] <= mode;
        m_user[d] <= DataIn;
        m_st[d]   <= stuck0;
        m_c15[d]  <= corrupt15;
      end
      else if (t[d] >= 1 && t[d] < done_t(d)) t[d] <= t[d] + 1;
      else if (t[d] == done_t(d)) t[d] <= 1000;
    end
  end

  always @(negedge clock) begin
    if (chk_en) begin
      for (int d = 0; d < 2; d++) begin
        int tt, lat, nc, ne, ff;
        logic [7:0] fd, ev;
        tt  = t[d];
        lat = d + 1;
        // Address j is compared in cycle 17+j+lat; its result shows one cycle later.
        nc  = (tt < 0) ? 0 : tt - 17 - lat;
        if (nc < 0) nc = 0;
        if (nc > 16) nc = 16;
        ne = 0; ff = -1; fd = 8'h00;
        for (int j = 0; j < nc; j++) begin
          ev = pat(m_mode[d], m_user[d], j);
          if (fault(ev, m_st[d], m_c15[d], j) != ev) begin
            if (ff < 0) begin ff = j; fd = fault(ev, m_st[d], m_c15[d], j); end
            ne++;
          end
        end
        chk($sformatf("busy[%0d] t=%0d", d, tt), busy_o[d], (tt >= 1 && tt <= 32 + lat));
        chk($sformatf("done[%0d] t=%0d", d, tt), done_o[d], (tt == 33 + lat));
        chk($sformatf("wren[%0d] t=%0d", d, tt), wren_o[d], (tt >= 1 && tt <= 16));
        chk($sformatf("pass[%0d] t=%0d", d, tt), pass_o[d], (tt >= 33 + lat && ne == 0));
        chk($sformatf("err_count[%0d] t=%0d", d, tt), err_o[d], ne);
        chk($sformatf("fail_address[%0d] t=%0d", d, tt), fa_o[d], (ff < 0) ? 0 : ff);
        chk($sformatf("fail_data[%0d] t=%0d", d, tt), fd_o[d], fd);
        if (tt >= 1 && tt <= 32)
          chk($sformatf("ram_address[%0d] t=%0d", d, tt), addr_o[d], (tt - 1) % 16);
        if (tt >= 1 && tt <= 16)
          chk($sformatf("ram_data[%0d] t=%0d", d, tt), data_o[d], pat(m_mode[d], m_user[d], tt - 1));
      end
    end
  end

  // Pulse start for one edge; returns at the negedge of the first write cycle.
  task automatic launch(input int d);
    @(negedge clock);
    start_i[d] = 1'b1;
    @(negedge clock);
    start_i[d] = 1'b0;
  endtask

  // Count cycles (current one = 1) until done, bounded.
  task automatic wait_done(input int d, output int n);
    n = 1;
    while (!done_o[d] && n < 200) begin
      @(negedge clock);
      n++;
    end
  endtask

  initial begin
    int n, cnt, dn;
    int dt [3];

    // Reset
    repeat (3) @(negedge clock);
    chk("reset busy", busy_o, 2'b00);
    chk("reset done", done_o, 2'b00);
    chk("reset pass", pass_o, 2'b00);
    chk("reset wren", wren_o, 2'b00);
    chk("reset err_count", err_o[0], 5'd0);
    chk("reset fail_address", fa_o[0], 4'd0);
    chk("reset fail_data", fd_o[0], 8'h00);
    chk_en = 1'b1;
    clear  = 1'b0;

    // Mode 10, clean RAM
    mode = 2'b10;
    launch(0);
    wait_done(0, n);
    chk("m10 done latency", n, 34);
    chk("m10 pass", pass_o[0], 1'b1);
    chk("m10 err_count", err_o[0], 5'd0);

    // Mode 11, bit 0 stuck low
    mode = 2'b11; stuck0 = 1'b1;
    launch(0);
    wait_done(0, n);
    chk("m11 done latency", n, 34);
    chk("m11 err_count", err_o[0], 5'd8);
    chk("m11 fail_address", fa_o[0], 4'd1);
    chk("m11 fail_data", fd_o[0], 8'hE0);
    chk("m11 pass", pass_o[0], 1'b0);
    @(negedge clock);
    stuck0 = 1'b0;

    // Mode 00, DataIn changes mid-run
    mode = 2'b00; DataIn = 8'hA5;
    launch(0);
    repeat (5) @(negedge clock);
    DataIn = 8'h3C;
    @(negedge clock);
    chk("m00 latched write data", data_o[0], 8'hA5);
    wait_done(0, n);
    chk("m00 done latency from E+7", n, 28);
    chk("m00 pass", pass_o[0], 1'b1);

    // Clear during READ at address 5
    mode = 2'b01;
    launch(0);
    repeat (21) @(negedge clock);
    chk("clr read address", addr_o[0], 4'd5);
    chk("clr read wren", wren_o[0], 1'b0);
    clear = 1'b1;
    @(negedge clock);
    clear = 1'b0;
    chk("clr busy", busy_o[0], 1'b0);
    chk("clr wren", wren_o[0], 1'b0);
    chk("clr err_count", err_o[0], 5'd0);
    cnt = 0;
    repeat (40) begin
      @(negedge clock);
      if (done_o[0]) cnt++;
    end
    chk("clr no done", cnt, 0);

    // Start pulsed again during WRITE is ignored
    mode = 2'b11;
    launch(0);
    repeat (4) @(negedge clock);
    start_i[0] = 1'b1;
    @(negedge clock);
    start_i[0] = 1'b0;
    cnt = 0;
    repeat (60) begin
      @(negedge clock);
      if (done_o[0]) cnt++;
    end
    chk("restart ignored, done pulses", cnt, 1);

    // Start held high: back-to-back runs
    mode = 2'b10;
    dt = '{0, 0, 0};
    @(negedge clock);
    start_i[0] = 1'b1;
    n = 0; dn = 0;
    while (dn < 3 && n < 200) begin
      @(negedge clock);
      n++;
      if (done_o[0]) begin
        dt[dn] = n;
        dn++;
      end
    end
    start_i[0] = 1'b0;
    chk("held first done", dt[0], 34);
    chk("held spacing 1", dt[1] - dt[0], 34);
    chk("held spacing 2", dt[2] - dt[1], 34);
    repeat (3) @(negedge clock);
    chk("held stops", busy_o[0], 1'b0);

    // RD_LAT=2, mode 01, clean then address 15 corrupted
    mode = 2'b01;
    launch(1);
    wait_done(1, n);
    chk("lat2 done latency", n, 35);
    chk("lat2 pass", pass_o[1], 1'b1);
    @(negedge clock);
    corrupt15 = 1'b1;
    launch(1);
    wait_done(1, n);
    chk("lat2 c15 done latency", n, 35);
    chk("lat2 c15 fail_address", fa_o[1], 4'd15);
    chk("lat2 c15 err_count", err_o[1], 5'd1);
    chk("lat2 c15 fail_data", fd_o[1], 8'h01);
    chk("lat2 c15 pass", pass_o[1], 1'b0);
    @(negedge clock);
    corrupt15 = 1'b0;
    repeat (3) @(negedge clock);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
